pdot_eat_controller: RTL and testbench

// Sits between the pacman/collision logic and the pac-dot generator. Detects

---
 rtl/pdot_eat_controller.sv | 119 +++++++++++
 tb/tb_pdot_eat_controller.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/pdot_eat_controller.sv
// Pac-dot eat controller: flags pacman/dot overlap to the dot generator, credits
// at most MAX_EAT_PER_FRM dots per frame into a saturating BCD score, runs the level-clear countdown.
module pdot_eat_controller #(
    parameter int DOT_POINTS      = 10,
    parameter int CLEAR_FRAMES    = 60,
    parameter int MAX_EAT_PER_FRM = 1
) (
    input  logic        clk,
    input  logic        resetN,
    input  logic        startOfFrame,
    input  logic        game_start,
    input  logic        pacman_dr,
    input  logic        pdots_dr,
    input  logic        pdots_exist,
    output logic        remove_cur_pdot,
    output logic        eat_pulse,
    output logic [15:0] score_bcd,
    output logic [8:0]  dots_eaten,
    output logic        level_active,
    output logic        level_clear
);

    typedef enum logic [1:0] {IDLE, PLAY, CLEAR_WAIT, CLEARED} state_t;

    localparam logic [3:0] PTS_ONES   = 4'(DOT_POINTS % 10);
    localparam logic [3:0] PTS_TENS   = 4'(DOT_POINTS / 10);
    localparam logic [7:0] MAX_EAT    = 8'(MAX_EAT_PER_FRM);
    localparam logic [7:0] CLEAR_LOAD = 8'(CLEAR_FRAMES);

    state_t      state;
    logic [7:0]  frame_left;
    logic [7:0]  frame_eaten_cnt;
    logic [7:0]  eaten_base;
    logic        hit;
    logic        credit;
    logic [15:0] score_sum;
    logic [4:0]  digit_sum;
    logic        carry;

    // Must stay combinational: the generator clears the mask bit while the scan is still in this tile.
    assign hit             = pacman_dr & pdots_dr & (state == PLAY);
    assign remove_cur_pdot = hit;

    // A frame start coinciding with a hit clears the quota first, so that hit opens the new frame.
    assign eaten_base = startOfFrame ? 8'd0 : frame_eaten_cnt;
    assign credit     = hit && (eaten_base < MAX_EAT);

    // NOTE: every variable assigned in always_comb gets a default first, otherwise a latch is inferred.
    always_comb begin
        score_sum = score_bcd;
        carry     = 1'b0;
        digit_sum = '0;
        for (int i = 0; i < 4; i++) begin
            digit_sum = {1'b0, score_bcd[4*i +: 4]} + {4'b0, carry};
            if (i == 0)
                digit_sum = digit_sum + {1'b0, PTS_ONES};
            else if (i == 1)
                digit_sum = digit_sum + {1'b0, PTS_TENS};
            carry = (digit_sum > 5'd9);
            if (carry)
                digit_sum = digit_sum - 5'd10;
            score_sum[4*i +: 4] = digit_sum[3:0];
        end
        if (carry)
            score_sum = 16'h9999;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state           <= IDLE;
            frame_left      <= '0;
            frame_eaten_cnt <= '0;
            eat_pulse       <= 1'b0;
            score_bcd       <= 16'h0000;
            dots_eaten      <= '0;
            level_active    <= 1'b0;
            level_clear     <= 1'b0;
        end else begin
            level_clear     <= 1'b0;
            eat_pulse       <= credit;
            frame_eaten_cnt <= eaten_base + {7'b0, credit};

            // Credit lands even on the cycle the level ends, before CLEAR_WAIT is entered.
            if (credit) begin
                score_bcd <= score_sum;
                if (dots_eaten != 9'd511)
                    dots_eaten <= dots_eaten + 9'd1;
            end

            if (game_start) begin
                state        <= PLAY;
                dots_eaten   <= '0;
                level_active <= 1'b1;
            end else begin
                case (state)
                    PLAY: begin
                        if (!pdots_exist) begin
                            state        <= CLEAR_WAIT;
                            frame_left   <= CLEAR_LOAD;
                            level_active <= 1'b0;
                        end
                    end
                    CLEAR_WAIT: begin
                        if (startOfFrame) begin
                            frame_left <= frame_left - 8'd1;
                            if (frame_left == 8'd1) begin
                                state       <= CLEARED;
                                level_clear <= 1'b1;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pdot_eat_controller.sv
// Bench for pdot_eat_controller: directed sequence with randomized draw requests,
// checked cycle by cycle against an arithmetic model of score, dot count and level flow.
module tb_pdot_eat_controller;

    localparam int CF      = 60;
    localparam int PTS     = 10;
    localparam int MAX_EAT = 1;

    localparam int M_IDLE = 0;
    localparam int M_PLAY = 1;
    localparam int M_WAIT = 2;
    localparam int M_DONE = 3;

    logic        clk = 1'b0;
    logic        resetN = 1'b0;
    logic        startOfFrame = 1'b0;
    logic        game_start = 1'b0;
    logic        pacman_dr = 1'b0;
    logic        pdots_dr = 1'b0;
    logic        pdots_exist = 1'b1;
    logic        remove_cur_pdot;
    logic        eat_pulse;
    logic [15:0] score_bcd;
    logic [8:0]  dots_eaten;
    logic        level_active;
    logic        level_clear;

    int compared   = 0;
    int mismatched = 0;
    int clear_seen = 0;

    int m_mode, m_score, m_dots, m_credits, m_left;
    bit m_pulse, m_clear;

    always #5 clk = ~clk;

    pdot_eat_controller #(
        .DOT_POINTS     (PTS),
        .CLEAR_FRAMES   (CF),
        .MAX_EAT_PER_FRM(MAX_EAT)
    ) dut (
        .clk            (clk),
        .resetN         (resetN),
        .startOfFrame   (startOfFrame),
        .game_start     (game_start),
        .pacman_dr      (pacman_dr),
        .pdots_dr       (pdots_dr),
        .pdots_exist    (pdots_exist),
        .remove_cur_pdot(remove_cur_pdot),
        .eat_pulse      (eat_pulse),
        .score_bcd      (score_bcd),
        .dots_eaten     (dots_eaten),
        .level_active   (level_active),
        .level_clear    (level_clear)
    );

    function automatic logic [15:0] to_bcd(input int v);
        return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    task chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task model_reset;
        m_mode = M_IDLE; m_score = 0; m_dots = 0; m_credits = 0; m_left = 0;
        m_pulse = 1'b0; m_clear = 1'b0;
    endtask

    // Applies the rules for one clock edge using the inputs currently driven.
    task model_update(input bit h);
        int  base;
        bit  cred;
        base      = startOfFrame ? 0 : m_credits;
        cred      = h && (base < MAX_EAT);
        m_credits = base + (cred ? 1 : 0);
        m_pulse   = cred;
        m_clear   = 1'b0;
        if (cred) begin
            m_score = (m_score + PTS > 9999) ? 9999 : m_score + PTS;
            if (m_dots < 511) m_dots++;
        end
        if (game_start) begin
            m_mode = M_PLAY;
            m_dots = 0;
        end else if (m_mode == M_PLAY && !pdots_exist) begin
            m_mode = M_WAIT;
            m_left = CF;
        end else if (m_mode == M_WAIT && startOfFrame) begin
            m_left--;
            if (m_left == 0) begin
                m_mode  = M_DONE;
                m_clear = 1'b1;
            end
        end
    endtask

    task check_outputs;
        chk("eat_pulse",    eat_pulse,    m_pulse);
        chk("score_bcd",    score_bcd,    to_bcd(m_score));
        chk("dots_eaten",   dots_eaten,   m_dots);
        chk("level_active", level_active, m_mode == M_PLAY);
        chk("level_clear",  level_clear,  m_clear);
        if (level_clear === 1'b1) clear_seen++;
    endtask

    // One clock: drive inputs, check the combinational remove, then the registered outputs.
    task step(input bit s, input bit g, input bit p, input bit d, input bit e);
        bit h;
        startOfFrame = s; game_start = g; pacman_dr = p; pdots_dr = d; pdots_exist = e;
        h = p && d && (m_mode == M_PLAY);
        #1;
        chk("remove_cur_pdot", remove_cur_pdot, h);
        @(posedge clk);
        model_update(h);
        #1;
        check_outputs();
    endtask

    task random_frames(input int n, input bit e);
        int len;
        for (int f = 0; f < n; f++) begin
            len = int'($urandom_range(2, 7));
            step(1'b1, 1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), e);
            for (int c = 1; c < len; c++)
                step(1'b0, 1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), e);
        end
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_outputs();
        chk("reset_remove", remove_cur_pdot, 1'b0);
        #2 resetN = 1'b1;
        @(posedge clk);
        #1;

        // Hits while idle are ignored.
        repeat (2) step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);

        // Three hit pixels in one frame credit one dot.
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        repeat (3) step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        repeat (3) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("t1_score", score_bcd, 16'h0010);
        chk("t1_dots", dots_eaten, 9'd1);

        // Five separate frames, one hit each.
        for (int f = 0; f < 5; f++) begin
            step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
            step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
            step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        end
        chk("t2_score", score_bcd, 16'h0060);
        chk("t2_dots", dots_eaten, 9'd6);

        random_frames(150, 1'b1);

        // Frame start coinciding with a hit, driven up to both saturation points.
        while (m_score < 9999 || m_dots < 511) begin
            step(1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
            step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        end
        repeat (2) begin
            step(1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
            step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        end
        chk("sat_score", score_bcd, 16'h9999);
        chk("sat_dots", dots_eaten, 9'd511);

        // Restart keeps the score, clears the dot count.
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        chk("restart_dots", dots_eaten, 9'd0);
        step(1'b1, 1'b0, 1'b1, 1'b1, 1'b1);

        // Last dot credited in the same cycle pdots_exist falls.
        step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        chk("last_dot_dots", dots_eaten, 9'd2);
        clear_seen = 0;
        for (int f = 0; f < CF; f++) begin
            step(1'b1, 1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
            step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
            step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        end
        repeat (3) step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        chk("clear_pulses", clear_seen, 1);
        chk("cleared_active", level_active, 1'b0);
        random_frames(3, 1'b0);

        // New level from CLEARED, then a restart during CLEAR_WAIT.
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        random_frames(10, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        random_frames(20, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        random_frames(4, 1'b1);
        chk("restart_no_clear", clear_seen, 1);

        // Asynchronous reset in the middle of CLEAR_WAIT.
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        random_frames(10, 1'b0);
        startOfFrame = 1'b0; game_start = 1'b0; pacman_dr = 1'b0; pdots_dr = 1'b0;
        #2 resetN = 1'b0;
        #1;
        model_reset();
        check_outputs();
        @(posedge clk);
        #2 resetN = 1'b1;
        @(posedge clk);
        #1;
        check_outputs();
        chk("reset_no_clear", clear_seen, 1);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("post_reset_score", score_bcd, 16'h0010);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
